// File: rtl/nikhilam_pkg.sv
// Shared types and width helpers for the sequential Nikhilam multiplier.
package nikhilam_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        COMP = 3'd1,
        MUL  = 3'd2,
        SUM  = 3'd3,
        DONE = 3'd4
    } nikhilam_state_t;

    // Deviation 2^W - x needs one extra bit so that x=0 maps to 2^W.
    function automatic int dev_w(input int w);
        return w + 1;
    endfunction

    // Signed cross term a - cb spans -2^W .. 2^W-2.
    function automatic int cross_w(input int w);
        return w + 2;
    endfunction

    function automatic int acc_w(input int w);
        return 2 * w + 2;
    endfunction

endpackage

// File: rtl/nikhilam_shift_add_mul.sv
// Iterative LSB-first shift-add multiplier for the Nikhilam deviation product.
// NIKHILAM_EARLY_EXIT_EN: stop as soon as the remaining multiplier bits are zero.
module nikhilam_shift_add_mul
    import nikhilam_pkg::*;
#(
    parameter int N = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N-1:0]     ca,
    input  logic [N-1:0]     cb,
    output logic             done,
    output logic [2*N-1:0]   acc
);

    localparam int CW = $clog2(N);

    logic [2*N-1:0] mcand_q;
    logic [2*N-1:0] acc_q;
    logic [N-1:0]   mplier_q;
    logic [CW-1:0]  cnt_q;
    logic           run_q;
    logic           last;

`ifdef NIKHILAM_EARLY_EXIT_EN
    // Bits above the one consumed this cycle are all zero: nothing left to add.
    assign last = (cnt_q == CW'(N - 1)) || (mplier_q[N-1:1] == '0);
`else
    assign last = (cnt_q == CW'(N - 1));
`endif

    assign done = run_q && last;
    assign acc  = acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start) begin
            mcand_q  <= {{N{1'b0}}, ca};
            acc_q    <= '0;
            mplier_q <= cb;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (run_q) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (last) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/nikhilam_mult_seq.sv
// Sequential base-2^WIDTH Nikhilam multiplier: p = (a - cb)<<W + ca*cb.
// Optional NIKHILAM_EARLY_EXIT_EN shortens the MUL phase (see sub-module).
module nikhilam_mult_seq
    import nikhilam_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy
);

    localparam int W  = WIDTH;
    localparam int DW = dev_w(W);
    localparam int XW = cross_w(W);
    localparam int AW = acc_w(W);

    nikhilam_state_t state_q, state_d;

    logic [W-1:0]   a_q, b_q;
    logic [DW-1:0]  ca, cb;
    logic [XW-1:0]  hi_d, hi_q;
    logic [AW-1:0]  acc, sum;
    logic [2*W-1:0] out_p_q;
    logic           start, mul_done;
    logic           unused_sum_hi;

    assign ca   = {1'b1, {W{1'b0}}} - {1'b0, a_q};
    assign cb   = {1'b1, {W{1'b0}}} - {1'b0, b_q};
    assign hi_d = {2'b00, a_q} - {1'b0, cb};

    // hi<<W in AW bits is exactly {hi, W zeros}; two's complement wraps correctly.
    assign sum           = {hi_q, {W{1'b0}}} + acc;
    assign unused_sum_hi = ^sum[AW-1:2*W];

    nikhilam_shift_add_mul #(.N(DW)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .ca    (ca),
        .cb    (cb),
        .done  (mul_done),
        .acc   (acc)
    );

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: if (in_valid) state_d = COMP;
            COMP: begin
                start   = 1'b1;
                state_d = MUL;
            end
            MUL:  if (mul_done) state_d = SUM;
            SUM:  state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            out_p_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                a_q <= in_a;
                b_q <= in_b;
            end
            if (state_q == COMP) begin
                hi_q <= hi_d;
            end
            if (state_q == SUM) begin
                out_p_q <= sum[2*W-1:0];
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_p     = out_p_q;

endmodule

// File: tb/tb_nikhilam_mult_seq.sv
// Scoreboard bench for nikhilam_mult_seq: WIDTH=8 directed cases and WIDTH=4 exhaustive.
module tb_nikhilam_mult_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        iv8, ir8, ov8, or8, bz8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic        iv4, ir4, ov4, or4, bz4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;

    nikhilam_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
        .out_valid(ov8), .out_ready(or8), .out_p(p8), .busy(bz8));

    nikhilam_mult_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_a(a4), .in_b(b4),
        .out_valid(ov4), .out_ready(or4), .out_p(p4), .busy(bz4));

    typedef struct { int p; int acc_cyc; int lat; } exp_t;
    exp_t q8[$];
    exp_t q4[$];

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    task automatic flag(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Latency counted inclusively from the accept edge to the edge raising out_valid.
    function automatic int exp_lat(input int w, input int b);
`ifdef NIKHILAM_EARLY_EXIT_EN
        int cbv = (1 << w) - b;
        int n = 0;
        for (int i = 0; i <= w; i++) if (cbv[i]) n = i + 1;
        return 3 + n;
`else
        return w + 4;
`endif
    endfunction

    // Monitors sample on the falling edge; drivers change on rising edge + 1.
    initial begin
        bit seen = 0;
        forever begin
            @(negedge clk);
            if (ir8 && ov8) flag("excl8 in_ready and out_valid both high");
            if (!rst_n) seen = 0;
            else if (ov8) begin
                if (q8.size() == 0) flag("spurious8 out_valid with empty scoreboard");
                else begin
                    if (!seen) begin
                        seen = 1;
                        chk("lat8", cyc - q8[0].acc_cyc + 1, q8[0].lat);
                    end
                    chk("p8", p8, q8[0].p);
                    if (or8) begin
                        void'(q8.pop_front());
                        seen = 0;
                    end
                end
            end
        end
    end

    initial begin
        bit seen = 0;
        forever begin
            @(negedge clk);
            if (ir4 && ov4) flag("excl4 in_ready and out_valid both high");
            if (!rst_n) seen = 0;
            else if (ov4) begin
                if (q4.size() == 0) flag("spurious4 out_valid with empty scoreboard");
                else begin
                    if (!seen) begin
                        seen = 1;
                        chk("lat4", cyc - q4[0].acc_cyc + 1, q4[0].lat);
                    end
                    chk("p4", p4, q4[0].p);
                    if (or4) begin
                        void'(q4.pop_front());
                        seen = 0;
                    end
                end
            end
        end
    end

    // Random back-pressure on the narrow instance.
    initial begin
        or4 = 1'b1;
        forever begin
            @(posedge clk);
            #1 or4 = 1'($urandom_range(0, 1));
        end
    end

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input int p, input bit push);
        int t = 0;
        iv8 = 1'b1; a8 = a; b8 = b;
        @(negedge clk);
        while (!ir8 && t < 200) begin @(negedge clk); t++; end
        if (!ir8) flag("accept8 timeout");
        else if (push) q8.push_back('{p, cyc + 1, exp_lat(8, int'(b))});
        @(posedge clk);
        #1 iv8 = 1'b0;
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input int p);
        int t = 0;
        iv4 = 1'b1; a4 = a; b4 = b;
        @(negedge clk);
        while (!ir4 && t < 200) begin @(negedge clk); t++; end
        if (!ir4) flag("accept4 timeout");
        else q4.push_back('{p, cyc + 1, exp_lat(4, int'(b))});
        @(posedge clk);
        #1 iv4 = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q8.size() != 0 || q4.size() != 0) && t < 1000) begin @(posedge clk); t++; end
        #1;
        if (q8.size() != 0 || q4.size() != 0) flag("drain timeout");
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b1;
        iv4 = 1'b0; a4 = '0; b4 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready8", ir8, 1);
        chk("rst_out_valid8", ov8, 0);
        chk("rst_out_p8", p8, 0);
        chk("rst_busy8", bz8, 0);
        chk("rst_out_p4", p4, 0);
        chk("rst_busy4", bz4, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1, 2: zero operand and all-ones operands
        issue8(8'd0, 8'd5, 0, 1);
        drain();
        issue8(8'd255, 8'd255, 65025, 1);
        drain();

        // 3: output held under back-pressure
        or8 = 1'b0;
        issue8(8'd200, 8'd3, 600, 1);
        t = 0;
        while (!ov8 && t < 100) begin @(posedge clk); #1; t++; end
        if (!ov8) flag("wait out_valid8 timeout");
        chk("stall_in_ready8", ir8, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("stall_hold_p8", p8, 600);
        chk("stall_busy8", bz8, 1);
        or8 = 1'b1;
        @(posedge clk); #1;
        chk("post_hs_busy8", bz8, 0);
        chk("post_hs_in_ready8", ir8, 1);
        chk("post_hs_out_valid8", ov8, 0);
        drain();

        // 5: reset during the third MUL cycle discards the operation
        issue8(8'd77, 8'd13, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_busy8", bz8, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid8", ov8, 0);
        chk("arst_out_p8", p8, 0);
        chk("arst_busy8", bz8, 0);
        chk("arst_in_ready8", ir8, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue8(8'd6, 8'd7, 42, 1);
        drain();

        // 6: second pair offered while busy is held off until IDLE
        issue8(8'd10, 8'd10, 100, 1);
        issue8(8'd3, 8'd3, 9, 1);
        drain();

        // 4: exhaustive narrow instance
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                issue4(4'(a), 4'(b), a * b);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
